spi_xfer_sequencer: RTL and testbench
=====================================

// Module: spi_xfer_sequencer
// PURPOSE
//   Upstream byte sequencer for the 8-bit SPI master. Host loads a burst of
//   TX bytes into an internal FIFO, then pulses start with a byte count; the
//   block feeds the master one byte per en/busy handshake and stores each
//   received byte in an RX FIFO for host read-back. Flags timeouts and drops.
// PARAMETERS
//   FIFO_DEPTH  16    entries per TX and RX FIFO (power of 2, >=2)
//   LEN_W       5     width of xfer_len; max burst = 2^LEN_W-1 bytes
//   TIMEOUT     1023  clk cycles allowed per busy edge before abort
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-low
//   wr_en        in   1      push wr_data into TX FIFO
//   wr_data      in   8      TX byte
//   tx_full      out  1      TX FIFO full
//   tx_count     out  LEN_W+1 bytes held in TX FIFO
//   rd_en        in   1      pop RX FIFO (rd_data valid same cycle, pre-pop)
//   rd_data      out  8      head of RX FIFO
//   rx_empty     out  1      RX FIFO empty
//   start        in   1      one-cycle pulse: begin burst of xfer_len bytes
//   xfer_len     in   LEN_W  burst length, sampled on start
//   active       out  1      burst in progress
//   done         out  1      one-cycle pulse: burst finished (ok or abort)
//   err          out  3      sticky {timeout, start_refused, tx_overflow}
//   err_clr      in   1      clears err
//   spi_en       out  1      launch request to SPI master
//   spi_tx_data  out  8      byte presented to master; stable while spi_en=1
//   spi_busy     in   1      master busy
//   spi_rx_data  in   8      master received byte
// BEHAVIOUR
// - Reset (rst=0 at posedge clk): both FIFOs empty, state IDLE; spi_en=0,
//   spi_tx_data=0, active=0, done=0, err=0, tx_full=0, rx_empty=1,
//   tx_count=0, rd_data=0. Reset mid-burst aborts at once, no done pulse.
// - FSM: IDLE -> LOAD -> LAUNCH -> WAIT_END -> STORE -> (LOAD | FINISH) -> IDLE.
//   IDLE: on start: xfer_len=0 -> FINISH; tx_count<xfer_len -> stay IDLE,
//     set err[1]; else latch remaining=xfer_len, active=1, go LOAD.
//   LOAD: wait until RX FIFO not full, then pop TX FIFO into spi_tx_data.
//   LAUNCH: spi_en=1 until spi_busy sampled 1, then spi_en=0, -> WAIT_END.
//   WAIT_END: on spi_busy sampled 0 -> STORE.
//   STORE: push spi_rx_data into RX FIFO, remaining-=1; 0 -> FINISH else LOAD.
//   FINISH: done=1 for one cycle, active=0, -> IDLE.
// - Timeout: cycle counter reset on entry to LAUNCH/WAIT_END; reaching
//   TIMEOUT sets err[2], drops spi_en, flushes TX FIFO, -> FINISH.
// - start while active is ignored (no error). busy is sampled only in LAUNCH
//   and WAIT_END; spi_busy=1 seen in IDLE/LOAD is ignored.
// - TX FIFO: wr_en when full drops byte, sets err[0]; wr_en and pop in same
//   cycle when full is legal (count unchanged). RX FIFO never overflows
//   (LOAD stalls). rd_en when empty: no change, rd_data holds.
// - Pointers are log2(FIFO_DEPTH) bits and wrap; counts are +1 bit wide.
// - err_clr and a new error in same cycle: new error wins (bit stays set).
// - Minimum per-byte overhead: 4 clk + master busy time.
// TESTING
// 1 Write 0xA5,0x3C; start len=2; model master echoes ~tx -> spi_tx_data
//   0xA5 then 0x3C, rd_data 0x5A then 0xC3, one done pulse, tx_count=0.
// 2 Write 1 byte; start len=3 -> err=3'b010, active stays 0, no spi_en.
// 3 Master never asserts busy -> after 1023 cycles err[2]=1, spi_en=0, done.
// 4 Fill RX FIFO (16 bytes) no reads, start len=1 -> stalls in LOAD with
//   spi_en=0; one rd_en -> transfer proceeds, done pulses.
// 5 17 writes into empty TX FIFO -> tx_full=1, tx_count=16, err[0]=1.
// 6 rst=0 during WAIT_END -> next cycle spi_en=0, active=0, FIFOs empty,
//   no done pulse; start len=0 afterwards -> done exactly 2 cycles later.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Byte sequencer between a host and an 8-bit SPI master. It drains a TX FIFO one byte per
// en/busy handshake and captures each received byte into an RX FIFO.
module spi_xfer_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             tx_full,
  output logic [LEN_W:0]   tx_count,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rx_empty,
  input  logic             start,
  input  logic [LEN_W-1:0] xfer_len,
  output logic             active,
  output logic             done,
  output logic [2:0]       err,
  input  logic             err_clr,
  output logic             spi_en,
  output logic [7:0]       spi_tx_data,
  input  logic             spi_busy,
  input  logic [7:0]       spi_rx_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StLaunch, StWaitEnd, StStore, StFinish
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CNT_W-1:0] rx_cnt_q;

  logic [LEN_W-1:0] remain_q, remain_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       spi_tx_data_q;
  logic [2:0]       err_q, err_d;
  logic             done_q;

  logic tx_push, tx_pop, tx_flush, tx_empty;
  logic rx_push, rx_pop, rx_full;
  logic err_tmo, err_refused, err_ovf;

  // FIFO status and handshake qualification
  always_comb begin
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == FullCnt);
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == FullCnt);
    // A write into a full FIFO is still accepted when a pop frees a slot that cycle.
    tx_push  = wr_en && (!tx_full || tx_pop);
    err_ovf  = wr_en && !tx_push;
    rx_pop   = rd_en && !rx_empty;
    err_d    = (err_clr ? 3'b000 : err_q) | {err_tmo, err_refused, err_ovf};
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    tmo_d       = tmo_q;
    tx_pop      = 1'b0;
    tx_flush    = 1'b0;
    rx_push     = 1'b0;
    err_tmo     = 1'b0;
    err_refused = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (xfer_len == '0) begin
            state_d = StFinish;
          end else if ({1'b0, xfer_len} > tx_count) begin
            err_refused = 1'b1;
          end else begin
            remain_d = xfer_len;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        // Holding here while RX is full is what keeps the RX FIFO from overflowing.
        if (!rx_full && !tx_empty) begin
          tx_pop  = 1'b1;
          tmo_d   = '0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (spi_busy) begin
          tmo_d   = '0;
          state_d = StWaitEnd;
        end else if (tmo_q == TmoLast) begin
          err_tmo  = 1'b1;
          tx_flush = 1'b1;
          state_d  = StFinish;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitEnd: begin
        if (!spi_busy) begin
          state_d = StStore;
        end else if (tmo_q == TmoLast) begin
          err_tmo  = 1'b1;
          tx_flush = 1'b1;
          state_d  = StFinish;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StStore: begin
        rx_push  = 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = (remain_q == LEN_W'(1)) ? StFinish : StLoad;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      remain_q      <= '0;
      tmo_q         <= '0;
      spi_tx_data_q <= '0;
      err_q         <= '0;
      done_q        <= 1'b0;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_cnt_q      <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_cnt_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        rx_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= (state_q == StFinish);

      if (tx_pop) begin
        spi_tx_data_q <= tx_mem_q[tx_rd_ptr_q];
      end
      if (tx_push) begin
        tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      end
      // A flush discards everything queued; a byte written the same cycle survives.
      if (tx_flush) begin
        tx_rd_ptr_q <= tx_wr_ptr_q;
        tx_cnt_q    <= CNT_W'(tx_push);
      end else begin
        if (tx_pop) begin
          tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
        end
        tx_cnt_q <= tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      end

      if (rx_push) begin
        rx_mem_q[rx_wr_ptr_q] <= spi_rx_data;
        rx_wr_ptr_q           <= rx_wr_ptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      end
      rx_cnt_q <= rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= wr_data;
    end
  end

  assign tx_count    = (LEN_W + 1)'(tx_cnt_q);
  assign rd_data     = rx_mem_q[rx_rd_ptr_q];
  assign active      = state_q inside {StLoad, StLaunch, StWaitEnd, StStore};
  assign done        = done_q;
  assign err         = err_q;
  assign spi_en      = (state_q == StLaunch);
  assign spi_tx_data = spi_tx_data_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a vector table for host-side control plus
// hand-written burst, stall, timeout and mid-burst reset sequences against an echo master.
module tb_spi_xfer_sequencer;

  logic       clk, rst, wr_en, rd_en, start, err_clr, spi_busy;
  logic [7:0] wr_data, spi_rx_data;
  logic [4:0] xfer_len;
  logic       tx_full, rx_empty, active, done, spi_en;
  logic [5:0] tx_count;
  logic [7:0] rd_data, spi_tx_data;
  logic [2:0] err;

  spi_xfer_sequencer #(.FIFO_DEPTH(16), .LEN_W(5), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .start(start), .xfer_len(xfer_len), .active(active), .done(done), .err(err),
    .err_clr(err_clr), .spi_en(spi_en), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_rx_data(spi_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic kick(input logic [4:0] len);
    xfer_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk($sformatf("%s done", name), done, 1);
    tick();
    chk($sformatf("%s single done", name), done, 0);
  endtask

  // Echo master: answers each launch with 3 busy cycles and returns the inverted byte.
  logic       echo_on;
  logic [7:0] seen[$];
  initial begin
    spi_busy    = 1'b0;
    spi_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (echo_on && spi_en && !spi_busy) begin
        seen.push_back(spi_tx_data);
        spi_rx_data = ~spi_tx_data;
        spi_busy    = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        spi_busy = 1'b0;
      end
    end
  end

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] data;
    logic       st;
    logic [4:0] len;
    logic       clr;
    logic [5:0] e_cnt;
    logic       e_full;
    logic [2:0] e_err;
    logic       e_act;
    logic       e_done;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    int   en_cycles;
    logic stall_en, stall_act, spur_done;

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; start = 1'b0; err_clr = 1'b0;
    wr_data = 8'h00; xfer_len = 5'd0; echo_on = 1'b0;

    vecs[0] = '{"idle",      0, 8'h00, 0, 5'd0, 0, 6'd0, 0, 3'b000, 0, 0};
    vecs[1] = '{"wr1",       1, 8'h11, 0, 5'd0, 0, 6'd1, 0, 3'b000, 0, 0};
    vecs[2] = '{"refuse",    0, 8'h00, 1, 5'd3, 0, 6'd1, 0, 3'b010, 0, 0};
    vecs[3] = '{"refhold",   0, 8'h00, 0, 5'd0, 0, 6'd1, 0, 3'b010, 0, 0};
    vecs[4] = '{"clr",       0, 8'h00, 0, 5'd0, 1, 6'd1, 0, 3'b000, 0, 0};
    vecs[5] = '{"len0",      0, 8'h00, 1, 5'd0, 0, 6'd1, 0, 3'b000, 0, 0};
    vecs[6] = '{"len0done",  0, 8'h00, 0, 5'd0, 0, 6'd1, 0, 3'b000, 0, 1};
    vecs[7] = '{"len0after", 0, 8'h00, 0, 5'd0, 0, 6'd1, 0, 3'b000, 0, 0};
    vecs[8] = '{"clrnew",    1, 8'h21, 1, 5'd3, 1, 6'd2, 0, 3'b010, 0, 0};
    vecs[9] = '{"clr2",      0, 8'h00, 0, 5'd0, 1, 6'd2, 0, 3'b000, 0, 0};

    // Reset state
    repeat (3) tick();
    chk("rst spi_en", spi_en, 0);
    chk("rst spi_tx_data", spi_tx_data, 0);
    chk("rst active", active, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst tx_full", tx_full, 0);
    chk("rst rx_empty", rx_empty, 1);
    chk("rst tx_count", tx_count, 0);
    chk("rst rd_data", rd_data, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].data; start = vecs[i].st;
      xfer_len = vecs[i].len; err_clr = vecs[i].clr;
      tick();
      wr_en = 1'b0; start = 1'b0; err_clr = 1'b0;
      chk($sformatf("%s tx_count", vecs[i].name), tx_count, vecs[i].e_cnt);
      chk($sformatf("%s tx_full", vecs[i].name), tx_full, vecs[i].e_full);
      chk($sformatf("%s err", vecs[i].name), err, vecs[i].e_err);
      chk($sformatf("%s active", vecs[i].name), active, vecs[i].e_act);
      chk($sformatf("%s done", vecs[i].name), done, vecs[i].e_done);
      chk($sformatf("%s spi_en", vecs[i].name), spi_en, 0);
    end

    // Fill TX to 16, then one dropped write
    exp_tx = '{8'h11, 8'h21};
    for (int i = 2; i < 16; i++) begin
      push(8'h20 + 8'(i));
      exp_tx.push_back(8'h20 + 8'(i));
    end
    chk("fill tx_count", tx_count, 16);
    chk("fill tx_full", tx_full, 1);
    chk("fill err", err, 3'b000);
    push(8'hFF);
    chk("ovf err", err, 3'b001);
    chk("ovf tx_count", tx_count, 16);
    chk("ovf tx_full", tx_full, 1);

    // 16-byte burst fills the RX FIFO
    seen.delete();
    echo_on = 1'b1;
    kick(5'd16);
    wait_done("burst16", 1000);
    chk("burst16 seen size", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      chk($sformatf("burst16 tx[%0d]", i), seen[i], exp_tx[i]);
      exp_rx.push_back(~exp_tx[i]);
    end
    chk("burst16 tx_count", tx_count, 0);
    chk("burst16 rx_empty", rx_empty, 0);
    chk("burst16 err sticky", err, 3'b001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr err", err, 3'b000);

    // RX full: burst stalls in LOAD until one read frees a slot
    push(8'h77);
    kick(5'd1);
    stall_en  = 1'b0;
    stall_act = 1'b1;
    repeat (8) begin
      tick();
      stall_en  = stall_en | spi_en;
      stall_act = stall_act & active;
    end
    chk("stall spi_en", stall_en, 0);
    chk("stall active", stall_act, 1);
    chk("stall rd_data", rd_data, exp_rx[0]);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(exp_rx.pop_front());
    exp_rx.push_back(8'h88);
    wait_done("stall", 200);
    chk("stall tx", seen[seen.size()-1], 8'h77);

    // Drain RX, then an extra read on empty
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain rd[%0d]", i), rd_data, exp_rx[i]);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("drain rx_empty", rx_empty, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty read rx_empty", rx_empty, 1);

    // Basic two-byte burst
    seen.delete();
    push(8'hA5);
    push(8'h3C);
    kick(5'd2);
    wait_done("two", 200);
    chk("two seen size", seen.size(), 2);
    chk("two tx0", seen[0], 8'hA5);
    chk("two tx1", seen[1], 8'h3C);
    chk("two tx_count", tx_count, 0);
    chk("two rd0", rd_data, 8'h5A);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("two rd1", rd_data, 8'hC3);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("two rx_empty", rx_empty, 1);

    // Master never answers: timeout after 1023 launch cycles, TX flushed
    echo_on = 1'b0;
    push(8'h01);
    push(8'h02);
    kick(5'd1);
    en_cycles = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 1200) begin
      if (spi_en) en_cycles++;
      tick();
      cyc++;
    end
    chk("tmo done", done, 1);
    chk("tmo spi_en cycles", en_cycles, 1023);
    chk("tmo err", err, 3'b100);
    chk("tmo spi_en", spi_en, 0);
    chk("tmo tx_count", tx_count, 0);
    chk("tmo rx_empty", rx_empty, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset while waiting for busy to fall
    echo_on = 1'b1;
    push(8'h55);
    push(8'h66);
    kick(5'd2);
    cyc = 0;
    while (spi_en !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rstmid launch", spi_en, 1);
    tick();
    tick();
    chk("rstmid waitend spi_en", spi_en, 0);
    chk("rstmid waitend active", active, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstmid spi_en", spi_en, 0);
    chk("rstmid active", active, 0);
    chk("rstmid tx_count", tx_count, 0);
    chk("rstmid rx_empty", rx_empty, 1);
    chk("rstmid err", err, 0);
    spur_done = done;
    repeat (4) begin
      tick();
      spur_done = spur_done | done;
    end
    chk("rstmid no done", spur_done, 0);
    kick(5'd0);
    chk("len0 +1 done", done, 0);
    tick();
    chk("len0 +2 done", done, 1);
    tick();
    chk("len0 +3 done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
